// File: rtl/trena_agendador.sv
// Measurement scheduler for the trena datapath: single/continuous triggering with a pronto watchdog and bounded retries.
// Optional build macro TRENA_AGENDADOR_CONTADOR_EN enables the 8-bit completed-measurement counter (medidas).
module trena_agendador #(
  parameter int PERIODO        = 50_000_000,
  parameter int TIMEOUT        = 25_000_000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       modo,
  input  logic       botao,
  input  logic       pronto,
  output logic       mensurar,
  output logic       reinicia_trena,
  output logic       ocupado,
  output logic       erro,
  output logic [7:0] medidas,
  output logic [3:0] db_estado
);

  localparam int CONT_MAX = (PERIODO > TIMEOUT) ? PERIODO : TIMEOUT;
  localparam int CW       = (CONT_MAX > 1) ? $clog2(CONT_MAX) : 1;
  localparam logic [CW-1:0] C_TIMEOUT_FIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_PERIODO_FIM = CW'(PERIODO - 1);
  localparam logic [3:0]    C_MAX_TENT    = 4'(MAX_TENTATIVAS);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    OCIOSO    = 4'd1,
    DISPARA   = 4'd2,
    AGUARDA   = 4'd3,
    RECUPERA  = 4'd4,
    INTERVALO = 4'd5,
    FALHA     = 4'd6
  } estado_t;

  estado_t       r_estado;
  logic          r_botao_d;
  logic          r_borda;
  logic [CW-1:0] r_tempo;
  logic [3:0]    r_tentativas;
  logic [3:0]    w_tent_prox;
  logic          w_abandona;

  assign w_tent_prox = r_tentativas + 4'd1;
  assign w_abandona  = !ligar && (r_estado == DISPARA || r_estado == AGUARDA ||
                                  r_estado == RECUPERA || r_estado == INTERVALO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado     <= INICIAL;
      r_botao_d    <= 1'b0;
      r_borda      <= 1'b0;
      r_tempo      <= '0;
      r_tentativas <= 4'd0;
    end else begin
      // The edge is registered so ocioso only ever sees a one-cycle pulse; edges seen elsewhere are dropped.
      r_botao_d <= botao;
      r_borda   <= botao & ~r_botao_d;
      r_tempo   <= r_tempo + 1'b1;
      if (w_abandona) begin
        r_estado <= OCIOSO;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (ligar && (modo || r_borda))
              r_estado <= DISPARA;
          end
          DISPARA: begin
            r_tempo  <= '0;
            r_estado <= AGUARDA;
          end
          AGUARDA: begin
            // A completion in the same cycle as the last timeout count takes precedence.
            if (pronto) begin
              r_tentativas <= 4'd0;
              r_tempo      <= '0;
              r_estado     <= modo ? INTERVALO : OCIOSO;
            end else if (r_tempo == C_TIMEOUT_FIM) begin
              r_estado <= RECUPERA;
            end
          end
          RECUPERA: begin
            r_tentativas <= w_tent_prox;
            r_estado     <= (w_tent_prox == C_MAX_TENT) ? FALHA : DISPARA;
          end
          INTERVALO: begin
            if (!modo)
              r_estado <= OCIOSO;
            else if (r_tempo == C_PERIODO_FIM)
              r_estado <= DISPARA;
          end
          FALHA: begin
            if (!ligar) begin
              r_tentativas <= 4'd0;
              r_estado     <= OCIOSO;
            end
          end
          default: begin
            r_botao_d    <= 1'b0;
            r_borda      <= 1'b0;
            r_tempo      <= '0;
            r_tentativas <= 4'd0;
            r_estado     <= OCIOSO;
          end
        endcase
      end
    end
  end

`ifdef TRENA_AGENDADOR_CONTADOR_EN
  logic [7:0] r_medidas;
  logic       w_conclui;

  assign w_conclui = (r_estado == AGUARDA) && pronto && ligar;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_medidas <= 8'd0;
    else if (r_estado == INICIAL)
      r_medidas <= 8'd0;
    else if (w_conclui)
      r_medidas <= r_medidas + 8'd1;
  end

  assign medidas = r_medidas;
`else
  assign medidas = 8'd0;
`endif

  // Moore outputs decoded straight from the state register, so reset clears them at once.
  assign mensurar       = (r_estado == DISPARA);
  assign reinicia_trena = (r_estado == RECUPERA);
  assign ocupado        = (r_estado == DISPARA) || (r_estado == AGUARDA) || (r_estado == RECUPERA);
  assign erro           = (r_estado == FALHA);
  assign db_estado      = r_estado;

endmodule

// File: tb/tb_trena_agendador.sv
// Self-checking bench for trena_agendador: a per-cycle vector table for single shot, then directed multi-cycle sequences.
module tb_trena_agendador;

  localparam int PERIODO = 20;
  localparam int TIMEOUT = 10;
  localparam int MAXT    = 3;
`ifdef TRENA_AGENDADOR_CONTADOR_EN
  localparam bit MED_EN = 1'b1;
`else
  localparam bit MED_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, ligar, modo, botao, pronto;
  logic       mensurar, reinicia_trena, ocupado, erro;
  logic [7:0] medidas;
  logic [3:0] db_estado;

  trena_agendador #(.PERIODO(PERIODO), .TIMEOUT(TIMEOUT), .MAX_TENTATIVAS(MAXT)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .modo(modo), .botao(botao), .pronto(pronto),
    .mensurar(mensurar), .reinicia_trena(reinicia_trena), .ocupado(ocupado), .erro(erro),
    .medidas(medidas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int n_mens = 0;
  int n_rein = 0;
  int n_checks = 0;
  int n_err = 0;
  int exp_med = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (mensurar)       n_mens <= n_mens + 1;
    if (reinicia_trena) n_rein <= n_rein + 1;
  end

  typedef struct {
    logic       ligar, modo, botao, pronto;
    logic [3:0] est;
    logic       mens, ocup;
    int         med;
  } vec_t;

  vec_t vt [0:12];

  function automatic vec_t mk(input logic l, input logic m, input logic b, input logic p,
                              input logic [3:0] e, input logic mn, input logic oc, input int md);
    vec_t v;
    v.ligar = l; v.modo = m; v.botao = b; v.pronto = p;
    v.est = e; v.mens = mn; v.ocup = oc; v.med = md;
    return v;
  endfunction

  function automatic int med_exp(input int m);
    return MED_EN ? (m % 256) : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // sel: 0 = mensurar, 1 = reinicia_trena, 2 = erro
  task automatic wait_sig(input int sel, input int bound, output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clock);
      if ((sel == 0 && mensurar) || (sel == 1 && reinicia_trena) || (sel == 2 && erro)) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
  endtask

  // Holds pronto high during the cycle tagged 'tag'; returns 1 time unit after the following edge.
  task automatic pronto_em(input int tag);
    while (cyc < tag) begin
      @(posedge clock); #1;
    end
    pronto = 1'b1;
    @(posedge clock); #1;
    pronto = 1'b0;
  endtask

  task automatic aperta;
    botao = 1'b1;
    @(posedge clock); #1;
    botao = 1'b0;
  endtask

  task automatic chk_med(input string nm);
    chk(nm, medidas, med_exp(exp_med));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  d, d2, r, p, base;
    bit  ok;

    reset = 1'b1; ligar = 1'b0; modo = 1'b0; botao = 1'b0; pronto = 1'b0;

    // Single shot, one record per cycle: outputs are the state after the edge that consumed the inputs.
    vt[0] = mk(1, 0, 0, 0, 4'd1, 0, 0, 0);
    vt[1] = mk(1, 0, 1, 0, 4'd1, 0, 0, 0);
    vt[2] = mk(1, 0, 1, 0, 4'd2, 1, 1, 0);
    for (int i = 3; i <= 7; i++) vt[i] = mk(1, 0, 1, 0, 4'd3, 0, 1, 0);
    vt[8] = mk(1, 0, 1, 1, 4'd1, 0, 0, 1);
    for (int i = 9; i <= 11; i++) vt[i] = mk(1, 0, 1, 0, 4'd1, 0, 0, 1);
    vt[12] = mk(1, 0, 0, 0, 4'd1, 0, 0, 1);

    repeat (2) @(posedge clock);
    #2;
    chk("rst_mensurar", mensurar, 0);
    chk("rst_reinicia", reinicia_trena, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_erro", erro, 0);
    chk("rst_medidas", medidas, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      ligar = vt[i].ligar; modo = vt[i].modo; botao = vt[i].botao; pronto = vt[i].pronto;
      @(posedge clock); #2;
      chk($sformatf("v%0d_estado", i), db_estado, vt[i].est);
      chk($sformatf("v%0d_mensurar", i), mensurar, vt[i].mens);
      chk($sformatf("v%0d_ocupado", i), ocupado, vt[i].ocup);
      chk($sformatf("v%0d_medidas", i), medidas, med_exp(vt[i].med));
    end
    exp_med = 1;

    // Continuous mode: mensurar PERIODO+1 cycles after each pronto.
    modo = 1'b1;
    wait_sig(0, 100, d, ok);
    chk("cont_first_trigger", ok, 1);
    for (int n = 0; n < 2; n++) begin
      p = d + 3;
      pronto_em(p);
      exp_med++;
      chk($sformatf("cont%0d_estado_intervalo", n), db_estado, 5);
      chk_med($sformatf("cont%0d_medidas", n));
      wait_sig(0, 100, d, ok);
      chk($sformatf("cont%0d_spacing", n), d - p, PERIODO + 1);
    end
    pronto_em(d + 3);
    exp_med++;
    chk_med("cont_last_medidas");
    repeat (5) @(posedge clock);
    #1;
    modo = 1'b0;
    @(posedge clock); #2;
    chk("cont_stop_estado", db_estado, 1);
    base = n_mens;
    repeat (40) @(negedge clock);
    chk("cont_stop_no_trigger", n_mens - base, 0);

    // Timeout then successful retry.
    base = n_rein;
    aperta();
    wait_sig(0, 20, d, ok);
    chk("to_first_trigger", ok, 1);
    wait_sig(1, 40, r, ok);
    chk("to_reinicia_seen", ok, 1);
    // aguarda lasts TIMEOUT cycles, recupera is the next one.
    chk("to_reinicia_delay", r - d, TIMEOUT + 1);
    wait_sig(0, 20, d2, ok);
    chk("to_retry_delay", d2 - r, 1);
    pronto_em(d2 + 2);
    exp_med++;
    chk_med("to_medidas");
    chk("to_erro", erro, 0);
    chk("to_estado", db_estado, 1);
    repeat (15) @(negedge clock);
    chk("to_reinicia_count", n_rein - base, 1);

    // Failure after MAXT consecutive timeouts.
    base = n_rein;
    aperta();
    wait_sig(2, 200, r, ok);
    chk("falha_reached", ok, 1);
    chk("falha_reinicia_count", n_rein - base, MAXT);
    chk("falha_estado", db_estado, 6);
    chk("falha_ocupado", ocupado, 0);
    repeat (5) @(negedge clock);
    chk("falha_holds", erro, 1);
    ligar = 1'b0;
    @(posedge clock); #2;
    chk("falha_exit_estado", db_estado, 1);
    chk("falha_exit_erro", erro, 0);
    ligar = 1'b1;

    // ligar dropped mid-measurement abandons without a trena reset.
    base = n_rein;
    aperta();
    wait_sig(0, 20, d, ok);
    chk("abandon_trigger", ok, 1);
    repeat (3) @(negedge clock);
    ligar = 1'b0;
    @(posedge clock); #2;
    chk("abandon_estado", db_estado, 1);
    repeat (20) @(negedge clock);
    chk("abandon_no_reinicia", n_rein - base, 0);
    ligar = 1'b1;

    // pronto in the same cycle the timeout count is reached.
    base = n_rein;
    aperta();
    wait_sig(0, 20, d, ok);
    chk("sim_trigger", ok, 1);
    pronto_em(d + TIMEOUT);
    exp_med++;
    chk("sim_estado", db_estado, 1);
    chk_med("sim_medidas");
    repeat (15) @(negedge clock);
    chk("sim_no_reinicia", n_rein - base, 0);

    // Asynchronous reset while in aguarda.
    aperta();
    wait_sig(0, 20, d, ok);
    chk("ar_trigger", ok, 1);
    repeat (3) @(negedge clock);
    chk("ar_pre_estado", db_estado, 3);
    #2;
    reset = 1'b1;
    #1;
    exp_med = 0;
    chk("ar_mensurar", mensurar, 0);
    chk("ar_reinicia", reinicia_trena, 0);
    chk("ar_ocupado", ocupado, 0);
    chk("ar_erro", erro, 0);
    chk("ar_medidas", medidas, 0);
    chk("ar_estado", db_estado, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #2;
    chk("ar_restart_estado", db_estado, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
